// File: rtl/fp_arb_pkg.sv
// Shared types and constants for the fp add/sub arbiter slice.
// Provides fp32_t, rmode_t, op_e and the rounding-mode encodings.
package fp_arb_pkg;

    localparam int FP_W = 32;

    typedef logic [FP_W-1:0] fp32_t;
    typedef logic [2:0]      rmode_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    localparam rmode_t RM_RNE = 3'b000;
    localparam rmode_t RM_RTZ = 3'b001;
    localparam rmode_t RM_RDN = 3'b010;
    localparam rmode_t RM_RUP = 3'b011;
    localparam rmode_t RM_RMM = 3'b100;

endpackage

// File: rtl/fp_adder.sv
// Combinational IEEE 754 single-precision adder with RISC-V rounding modes.
// Ports: a, b, rmode (in); result, overflow, underflow (out).
module fp_adder
    import fp_arb_pkg::*;
(
    input  fp32_t  a,
    input  fp32_t  b,
    input  rmode_t rmode,
    output fp32_t  result,
    output logic   overflow,
    output logic   underflow
);

    logic        a_nan, b_nan, a_inf, b_inf;
    logic [7:0]  a_e, b_e, ex, ey, d;
    logic [23:0] a_m, b_m, mx, my;
    logic        swap, sx, sy, eff_sub, sticky;
    logic [26:0] lg, sm, n;
    logic [27:0] s;
    logic [4:0]  lz;
    logic [9:0]  e, sh;
    logic        g, rs, inexact, up, to_inf, res_sign, ovf;
    logic [30:0] packed_v, rnd;

    always_comb begin
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);

        // subnormals use exponent 1 with no hidden bit
        a_e = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
        b_e = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
        a_m = {a[30:23] != 8'd0, a[22:0]};
        b_m = {b[30:23] != 8'd0, b[22:0]};

        swap = b[30:0] > a[30:0];
        ex   = swap ? b_e : a_e;
        ey   = swap ? a_e : b_e;
        mx   = swap ? b_m : a_m;
        my   = swap ? a_m : b_m;
        sx   = swap ? b[31] : a[31];
        sy   = swap ? a[31] : b[31];
        d    = ex - ey;

        // three extra bits: guard, round, sticky
        lg = {mx, 3'b000};
        if (d > 8'd26) begin
            sm     = '0;
            sticky = |my;
        end else begin
            sm     = {my, 3'b000} >> d;
            sticky = |({my, 3'b000} & ~({27{1'b1}} << d));
        end
        sm[0] = sm[0] | sticky;

        eff_sub = sx ^ sy;
        s = eff_sub ? ({1'b0, lg} - {1'b0, sm})
                    : ({1'b0, lg} + {1'b0, sm});

        lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (s[i]) lz = 5'(26 - i);
        end

        e  = {2'b00, ex};
        sh = '0;
        if (s[27]) begin
            n = {s[27:2], s[1] | s[0]};
            e = e + 10'd1;
        end else begin
            // never shift below exponent 1; the rest stays subnormal
            if ({5'd0, lz} < e - 10'd1) sh = {5'd0, lz};
            else                        sh = e - 10'd1;
            n = s[26:0] << sh;
            e = e - sh;
        end

        g       = n[2];
        rs      = |n[1:0];
        inexact = g | rs;
        case (rmode)
            RM_RTZ:  up = 1'b0;
            RM_RDN:  up = inexact & sx;
            RM_RUP:  up = inexact & ~sx;
            RM_RMM:  up = g;
            default: up = g & (rs | n[3]);
        endcase

        // rounding carry ripples into the exponent field
        packed_v = {(n[26] ? e[7:0] : 8'd0), n[25:3]};
        rnd      = packed_v + 31'(up);
        ovf      = (e >= 10'd255) || (rnd[30:23] == 8'hFF);

        case (rmode)
            RM_RTZ:  to_inf = 1'b0;
            RM_RDN:  to_inf = sx;
            RM_RUP:  to_inf = ~sx;
            default: to_inf = 1'b1;
        endcase

        // exact cancellation gives -0 only when rounding down
        if (s == 28'd0 && eff_sub) res_sign = (rmode == RM_RDN);
        else                       res_sign = sx;

        overflow  = 1'b0;
        underflow = 1'b0;
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) begin
            result = 32'h7FC0_0000;
        end else if (a_inf) begin
            result = a;
        end else if (b_inf) begin
            result = b;
        end else if (ovf) begin
            result   = {sx, to_inf ? 31'h7F80_0000 : 31'h7F7F_FFFF};
            overflow = 1'b1;
        end else begin
            result    = {res_sign, rnd};
            underflow = ~n[26] & inexact;
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set req bit at or after ptr wins.
// Ports: req (in), ptr (in, search start), enable (in), grant (one-hot), grant_idx.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    input  logic             enable,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx
);

    logic            found;
    logic [ID_W-1:0] idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ID_W'((int'(ptr) + k) % N_REQ);
            if (enable && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = idx;
            end
        end
    end

endmodule

// File: rtl/fp_addsub_arbiter.sv
// Round-robin sharing of one fp_adder among N_REQ add/sub requesters.
// Ports: clk, rst_n; req_valid/ready/a/b/op/rmode per requester;
// rsp_valid/ready/result/id/overflow/underflow on the single response port.
// Option FP_ADDSUB_STICKY_FLAGS_EN: flag_clr, sticky_overflow, sticky_underflow.
module fp_addsub_arbiter
    import fp_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*32-1:0] req_a,
    input  logic [N_REQ*32-1:0] req_b,
    input  logic [N_REQ-1:0]   req_op,
    input  logic [N_REQ*3-1:0] req_rmode,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [31:0]        rsp_result,
    output logic [ID_W-1:0]    rsp_id,
    output logic               rsp_overflow,
    output logic               rsp_underflow
`ifdef FP_ADDSUB_STICKY_FLAGS_EN
    ,
    input  logic               flag_clr,
    output logic               sticky_overflow,
    output logic               sticky_underflow
`endif
);

    // the response register's valid bit is the state
    localparam logic [0:0] S_EMPTY = 1'b0;
    localparam logic [0:0] S_FULL  = 1'b1;

    logic [0:0]       state, state_nxt;
    logic [ID_W-1:0]  rr_ptr, grant_idx;
    logic [N_REQ-1:0] grant;
    logic             slot_free, any_grant;
    fp32_t            op_a, op_b, sum;
    rmode_t           op_rm;
    logic             ovf, unf;

    assign rsp_valid = (state == S_FULL);
    assign slot_free = !rsp_valid || rsp_ready;
    assign any_grant = |grant;
    assign req_ready = grant;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .enable    (slot_free),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // one-hot operand mux; subtraction flips only the sign of B
    always_comb begin
        op_a  = '0;
        op_b  = '0;
        op_rm = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                op_a  = req_a[i*FP_W +: FP_W];
                op_b  = req_b[i*FP_W +: FP_W];
                op_b[FP_W-1] = op_b[FP_W-1] ^ (op_e'(req_op[i]) == OP_SUB);
                op_rm = req_rmode[i*3 +: 3];
            end
        end
    end

    fp_adder u_add (
        .a         (op_a),
        .b         (op_b),
        .rmode     (op_rm),
        .result    (sum),
        .overflow  (ovf),
        .underflow (unf)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_EMPTY: if (any_grant) state_nxt = S_FULL;
            S_FULL:  if (rsp_ready && !any_grant) state_nxt = S_EMPTY;
            default: state_nxt = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_EMPTY;
            rr_ptr        <= '0;
            rsp_result    <= '0;
            rsp_id        <= '0;
            rsp_overflow  <= 1'b0;
            rsp_underflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (any_grant) begin
                rsp_result    <= sum;
                rsp_id        <= grant_idx;
                rsp_overflow  <= ovf;
                rsp_underflow <= unf;
                rr_ptr <= (grant_idx == ID_W'(N_REQ - 1))
                        ? '0 : grant_idx + ID_W'(1);
            end
        end
    end

`ifdef FP_ADDSUB_STICKY_FLAGS_EN
    // a new flag in the same cycle as flag_clr keeps the bit set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_overflow  <= 1'b0;
            sticky_underflow <= 1'b0;
        end else begin
            sticky_overflow  <= (sticky_overflow & ~flag_clr)
                              | (any_grant & ovf);
            sticky_underflow <= (sticky_underflow & ~flag_clr)
                              | (any_grant & unf);
        end
    end
`endif

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Directed bench for fp_addsub_arbiter with hand-computed IEEE results.
// Covers add, sub, round-robin, backpressure, overflow, rounding, reset.
module tb_fp_addsub_arbiter;

    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid, req_ready, req_op;
    logic [N*32-1:0] req_a, req_b;
    logic [N*3-1:0] req_rmode;
    logic           rsp_valid, rsp_ready;
    logic [31:0]    rsp_result;
    logic [1:0]     rsp_id;
    logic           rsp_overflow, rsp_underflow;
`ifdef FP_ADDSUB_STICKY_FLAGS_EN
    logic           flag_clr, sticky_overflow, sticky_underflow;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    fp_addsub_arbiter #(.N_REQ(N)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_op        (req_op),
        .req_rmode     (req_rmode),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .rsp_id        (rsp_id),
        .rsp_overflow  (rsp_overflow),
        .rsp_underflow (rsp_underflow)
`ifdef FP_ADDSUB_STICKY_FLAGS_EN
        ,
        .flag_clr         (flag_clr),
        .sticky_overflow  (sticky_overflow),
        .sticky_underflow (sticky_underflow)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a,
                           input logic [31:0] b, input logic op,
                           input logic [2:0] rm);
        req_valid[i]       = 1'b1;
        req_a[i*32 +: 32]  = a;
        req_b[i*32 +: 32]  = b;
        req_op[i]          = op;
        req_rmode[i*3 +: 3] = rm;
    endtask

    task automatic run_op(input int i, input logic [31:0] a,
                          input logic [31:0] b, input logic op,
                          input logic [2:0] rm, input logic [31:0] exp,
                          input logic eo, input logic eu,
                          input string tag);
        req_valid = '0;
        set_req(i, a, b, op, rm);
        rsp_ready = 1'b1;
        #1;
        chk({tag, ".rdy"}, 32'(req_ready), 32'(1 << i));
        step();
        req_valid = '0;
        chk({tag, ".vld"}, 32'(rsp_valid), 32'd1);
        chk({tag, ".id"}, 32'(rsp_id), 32'(i));
        chk({tag, ".res"}, rsp_result, exp);
        chk({tag, ".ovf"}, 32'(rsp_overflow), 32'(eo));
        chk({tag, ".unf"}, 32'(rsp_underflow), 32'(eu));
    endtask

    logic [31:0] av [4] = '{32'h3F80_0000, 32'h4000_0000,
                            32'h4040_0000, 32'h4080_0000};
    logic [31:0] sv [4] = '{32'h4000_0000, 32'h4040_0000,
                            32'h4080_0000, 32'h40A0_0000};

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        req_rmode = '0;
        rsp_ready = 1'b0;
`ifdef FP_ADDSUB_STICKY_FLAGS_EN
        flag_clr  = 1'b0;
`endif
        #12;
        chk("rst.vld", 32'(rsp_valid), 32'd0);
        chk("rst.res", rsp_result, 32'd0);
        chk("rst.id", 32'(rsp_id), 32'd0);
        chk("rst.ovf", 32'(rsp_overflow), 32'd0);
        chk("rst.unf", 32'(rsp_underflow), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // single add / sub
        run_op(0, 32'h3F80_0000, 32'h4000_0000, 1'b0, 3'b000,
               32'h4040_0000, 1'b0, 1'b0, "add");
        run_op(1, 32'h4040_0000, 32'h3F80_0000, 1'b1, 3'b000,
               32'h4000_0000, 1'b0, 1'b0, "sub");
        run_op(1, 32'h3F80_0000, 32'h3F80_0000, 1'b1, 3'b000,
               32'h0000_0000, 1'b0, 1'b0, "sub0");
        // moves the pointer back to 0
        run_op(3, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 3'b000,
               32'h4000_0000, 1'b0, 1'b0, "add3");

        // round robin with all four requesters valid
        for (int i = 0; i < N; i++)
            set_req(i, av[i], 32'h3F80_0000, 1'b0, 3'b000);
        rsp_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("rr.rdy", 32'(req_ready), 32'(1 << (k % N)));
            step();
            chk("rr.id", 32'(rsp_id), 32'(k % N));
            chk("rr.res", rsp_result, sv[k % N]);
        end

        // backpressure: held response is id 1, 3.0
        req_valid = '0;
        rsp_ready = 1'b0;
        set_req(2, 32'h4120_0000, 32'h4000_0000, 1'b1, 3'b000);
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp.rdy", 32'(req_ready), 32'd0);
            step();
            chk("bp.vld", 32'(rsp_valid), 32'd1);
            chk("bp.id", 32'(rsp_id), 32'd1);
            chk("bp.res", rsp_result, 32'h4040_0000);
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp.go", 32'(req_ready), 32'b0100);
        step();
        req_valid = '0;
        chk("bp.id2", 32'(rsp_id), 32'd2);
        chk("bp.res2", rsp_result, 32'h4100_0000);
        step();
        chk("drain.vld", 32'(rsp_valid), 32'd0);
        chk("drain.hold", rsp_result, 32'h4100_0000);

        // overflow and boundary values
        run_op(0, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 3'b000,
               32'h7F80_0000, 1'b1, 1'b0, "ovf_rne");
`ifdef FP_ADDSUB_STICKY_FLAGS_EN
        chk("sticky.set", 32'(sticky_overflow), 32'd1);
`endif
        run_op(1, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 3'b001,
               32'h7F7F_FFFF, 1'b1, 1'b0, "ovf_rtz");
        run_op(2, 32'h0000_0001, 32'h0000_0001, 1'b0, 3'b000,
               32'h0000_0002, 1'b0, 1'b0, "subn");
`ifdef FP_ADDSUB_STICKY_FLAGS_EN
        chk("sticky.hold", 32'(sticky_overflow), 32'd1);
        flag_clr = 1'b1;
        step();
        flag_clr = 1'b0;
        chk("sticky.clr", 32'(sticky_overflow), 32'd0);
`endif
        run_op(3, 32'h7F80_0000, 32'h7F80_0000, 1'b1, 3'b000,
               32'h7FC0_0000, 1'b0, 1'b0, "inf_nan");
        run_op(0, 32'h3F80_0000, 32'h3380_0000, 1'b0, 3'b000,
               32'h3F80_0000, 1'b0, 1'b0, "tie_rne");
        run_op(1, 32'h3F80_0000, 32'h3380_0000, 1'b0, 3'b011,
               32'h3F80_0001, 1'b0, 1'b0, "tie_rup");

        // reset while a response is held
        run_op(2, 32'h3F80_0000, 32'h4000_0000, 1'b0, 3'b000,
               32'h4040_0000, 1'b0, 1'b0, "pre_rst");
        rsp_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.vld", 32'(rsp_valid), 32'd0);
        chk("arst.res", rsp_result, 32'd0);
        chk("arst.id", 32'(rsp_id), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        set_req(3, 32'h4080_0000, 32'h3F80_0000, 1'b0, 3'b000);
        set_req(0, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 3'b000);
        rsp_ready = 1'b1;
        #1;
        chk("post.rdy0", 32'(req_ready), 32'b0001);
        step();
        chk("post.id0", 32'(rsp_id), 32'd0);
        chk("post.res0", rsp_result, 32'h4000_0000);
        req_valid[0] = 1'b0;
        #1;
        chk("post.rdy3", 32'(req_ready), 32'b1000);
        step();
        req_valid = '0;
        chk("post.id3", 32'(rsp_id), 32'd3);
        chk("post.res3", rsp_result, 32'h40A0_0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
